// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, with early exit
// on the first differing bit pair and a valid/ready result handshake.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater_than,
  output logic             less_than,
  output logic             equal_to,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    D_EQ,
    D_GT,
    D_LT
  } dec_t;

  state_t         state;
  dec_t           dec;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]  cnt;

  logic a_bit;
  logic b_bit;

  assign a_bit = a_sr[WIDTH-1];
  assign b_bit = b_sr[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dec          <= D_EQ;
      a_sr         <= '0;
      b_sr         <= '0;
      cnt          <= '0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      greater_than <= 1'b0;
      less_than    <= 1'b0;
      equal_to     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            cnt      <= CW'(WIDTH - 1);
            dec      <= D_EQ;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr <= a_sr << 1;
          b_sr <= b_sr << 1;
          // Stop on first difference; otherwise the LSB closes as equal.
          if (a_bit && !b_bit) begin
            dec          <= D_GT;
            state        <= HOLD;
            busy         <= 1'b0;
            out_valid    <= 1'b1;
            greater_than <= 1'b1;
          end else if (!a_bit && b_bit) begin
            dec       <= D_LT;
            state     <= HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            less_than <= 1'b1;
          end else if (cnt == '0) begin
            dec       <= D_EQ;
            state     <= HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            equal_to  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            greater_than <= 1'b0;
            less_than    <= 1'b0;
            equal_to     <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          in_ready     <= 1'b1;
          busy         <= 1'b0;
          out_valid    <= 1'b0;
          greater_than <= 1'b0;
          less_than    <= 1'b0;
          equal_to     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port: a  input  WIDTH  operand A, unsigned.
REQ-007 SHALL have port: b  input  WIDTH  operand B, unsigned.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: greater_than  output  1  A > B.
REQ-011 SHALL have port: less_than  output  1  A < B.
REQ-012 SHALL have port: equal_to  output  1  A == B.
REQ-013 SHALL have port: busy  output  1  comparison in progress (SHIFT state).

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, HOLD; in_ready = 1 only in IDLE, busy = 1 only in SHIFT, out_valid = 1 only in HOLD.
REQ-015 SHALL, in IDLE, on an edge with in_valid=1, capture a and b into shift registers, load bit counter with WIDTH-1, clear the decision to "equal", go to SHIFT.
REQ-016 SHALL, in IDLE with in_valid=0, remain in IDLE; a and b are don't-care.
REQ-017 SHALL, in SHIFT, examine exactly one bit pair per cycle, MSB first: a_bit=1,b_bit=0 -> decision GT; a_bit=0,b_bit=1 -> decision LT; equal bits -> decision unchanged.
REQ-018 SHALL terminate early: on the edge where the first differing bit pair is examined, record the decision and go to HOLD.
REQ-019 SHALL, when the LSB pair (counter=0) is examined with no difference found, record EQ and go to HOLD.
REQ-020 SHALL produce latency: accept at edge E0; first difference at bit position p -> out_valid high after edge E(WIDTH-p); equal operands -> out_valid high after edge E(WIDTH); maximum WIDTH cycles.
REQ-021 SHALL, in HOLD, drive exactly one of greater_than/less_than/equal_to high, stable until handshake.
REQ-022 SHALL drive greater_than, less_than, equal_to all 0 whenever out_valid=0.
REQ-023 SHALL, in HOLD on an edge with out_ready=1, go to IDLE; result outputs return to 0 on that edge.
REQ-024 SHALL, in HOLD with out_ready=0, hold state and results indefinitely (backpressure); in_valid ignored.
REQ-025 SHALL ignore in_valid in SHIFT and HOLD; a/b changes after capture SHALL NOT affect the result.
REQ-026 SHALL NOT accept a new pair on the handshake edge leaving HOLD; minimum one IDLE cycle between results.
REQ-027 SHALL size the bit counter as ceil(log2(WIDTH)) bits; counter SHALL NOT wrap below 0.

Reset
REQ-028 SHALL, on any edge with rst=1, force state IDLE, clear shift registers, counter and decision, regardless of current state.
REQ-029 SHALL drive after reset: in_ready=1, out_valid=0, busy=0, greater_than=0, less_than=0, equal_to=0.
REQ-030 SHALL ignore in_valid and out_ready on edges with rst=1; reset mid-SHIFT or mid-HOLD SHALL discard the comparison with no out_valid pulse.

Verification
REQ-031 SHALL verify: WIDTH=8, a=0x80, b=0x7F accepted at E0 -> out_valid=1, greater_than=1 after E1, busy high for one cycle.
REQ-032 SHALL verify: a=0x5A, b=0x5A -> equal_to=1, out_valid rises after E8, busy high 8 cycles.
REQ-033 SHALL verify: a=0x12, b=0x13 -> less_than=1 after E8; a=0x20, b=0x30 -> less_than=1 after E4.
REQ-034 SHALL verify: result held with out_ready=0 for 5 cycles while in_valid=1 and a/b toggle -> outputs unchanged, in_ready=0; out_ready=1 -> IDLE next edge, all result outputs 0.
REQ-035 SHALL verify: rst=1 for 2 cycles during SHIFT of a=0x01, b=0x00 -> no out_valid, in_ready=1 and all outputs 0 after reset.
REQ-036 SHALL verify: WIDTH=4 exhaustive 256 pairs against a >,<,== reference model, checking one-hot result and latency per REQ-020.
